interface_hcsr04: RTL and testbench



---
 rtl/interface_hcsr04_if.sv | 21 ++
 rtl/interface_hcsr04.sv | 172 +++++++++++++++++
 tb/tb_interface_hcsr04.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/interface_hcsr04_if.sv
// Ranging request/result bundle between the sonar control unit and the HC-SR04 front end.
// The front end is the slave; the control unit (plus the sensor echo line) is the master.
interface interface_hcsr04_if;
   logic        medir;
   logic        echo;
   logic        trigger;
   logic [11:0] medida;
   logic        pronto;
   logic        timeout;
   logic [3:0]  db_estado;

   modport master (
      output medir, echo,
      input  trigger, medida, pronto, timeout, db_estado
   );

   modport slave (
      input  medir, echo,
      output trigger, medida, pronto, timeout, db_estado
   );
endinterface

// File: rtl/interface_hcsr04.sv
// HC-SR04 front end: fires the trigger pulse, times the synchronised echo and
// reports the distance in centimetres as three saturating BCD digits.
module interface_hcsr04 #(
   parameter int unsigned TRIGGER_CYCLES = 500,
   parameter int unsigned CYCLES_PER_CM  = 2941,
   parameter int unsigned TIMEOUT_CYCLES = 2_500_000
) (
   input  logic                clock,
   input  logic                reset,
   interface_hcsr04_if.slave   bus
);

   localparam int unsigned TRG_W = $clog2(TRIGGER_CYCLES + 1);
   localparam int unsigned CYC_W = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [2:0] INICIAL       = 3'd0;
   localparam logic [2:0] PREPARACAO    = 3'd1;
   localparam logic [2:0] ENVIA_TRIGGER = 3'd2;
   localparam logic [2:0] ESPERA_ECHO   = 3'd3;
   localparam logic [2:0] MEDINDO       = 3'd4;
   localparam logic [2:0] ARMAZENAMENTO = 3'd5;
   localparam logic [2:0] FINAL         = 3'd6;

   logic             echo_m;
   logic             echo_s;
   logic [2:0]       state;
   logic [2:0]       state_next;
   logic             tmo_exit;
   logic [TRG_W-1:0] trg_cnt;
   logic [CYC_W-1:0] cyc_cnt;
   logic [TMO_W-1:0] tmo_cnt;
   logic [11:0]      bcd;
   logic [11:0]      bcd_inc;
   logic             timed_out;
   logic             trg_done;
   logic             tmo_hit;

   logic             trigger_q;
   logic             trigger_next;
   logic             pronto_q;
   logic             pronto_next;
   logic [3:0]       db_q;
   logic [3:0]       db_next;
   logic [11:0]      medida_q;
   logic             timeout_q;

   assign trg_done = (trg_cnt == TRG_W'(TRIGGER_CYCLES - 1));
   // >= so a timeout reached while handing over to medindo still ends the wait
   assign tmo_hit  = (tmo_cnt >= TMO_W'(TIMEOUT_CYCLES - 1));

   // Next state and next values of the state-decoded outputs
   always_comb begin
      state_next = state;
      tmo_exit   = 1'b0;
      case (state)
         INICIAL:       if (bus.medir) state_next = PREPARACAO;
         PREPARACAO:    state_next = ENVIA_TRIGGER;
         ENVIA_TRIGGER: if (trg_done) state_next = ESPERA_ECHO;
         ESPERA_ECHO: begin
            if (echo_s) begin
               state_next = MEDINDO;
            end else if (tmo_hit) begin
               state_next = ARMAZENAMENTO;
               tmo_exit   = 1'b1;
            end
         end
         MEDINDO: begin
            if (!echo_s) begin
               state_next = ARMAZENAMENTO;
            end else if (tmo_hit) begin
               state_next = ARMAZENAMENTO;
               tmo_exit   = 1'b1;
            end
         end
         ARMAZENAMENTO: state_next = FINAL;
         FINAL:         state_next = INICIAL;
         default:       state_next = INICIAL;
      endcase

      trigger_next = (state_next == ENVIA_TRIGGER);
      pronto_next  = (state_next == FINAL);
      db_next      = (state_next <= FINAL) ? {1'b0, state_next} : 4'hF;
   end

   // Saturating three-digit BCD increment
   always_comb begin
      bcd_inc = bcd;
      if (bcd != 12'h999) begin
         if (bcd[3:0] != 4'd9) begin
            bcd_inc[3:0] = bcd[3:0] + 4'd1;
         end else begin
            bcd_inc[3:0] = 4'd0;
            if (bcd[7:4] != 4'd9) begin
               bcd_inc[7:4] = bcd[7:4] + 4'd1;
            end else begin
               bcd_inc[7:4]  = 4'd0;
               bcd_inc[11:8] = bcd[11:8] + 4'd1;
            end
         end
      end
   end

   // State register and its decoded outputs
   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= INICIAL;
         trigger_q <= 1'b0;
         pronto_q  <= 1'b0;
         db_q      <= 4'h0;
      end else begin
         state     <= state_next;
         trigger_q <= trigger_next;
         pronto_q  <= pronto_next;
         db_q      <= db_next;
      end
   end

   // Echo synchroniser, counters and result registers
   always_ff @(posedge clock) begin
      if (!reset) begin
         echo_m    <= 1'b0;
         echo_s    <= 1'b0;
         trg_cnt   <= '0;
         cyc_cnt   <= '0;
         tmo_cnt   <= '0;
         bcd       <= 12'h000;
         timed_out <= 1'b0;
         medida_q  <= 12'h000;
         timeout_q <= 1'b0;
      end else begin
         echo_m <= bus.echo;
         echo_s <= echo_m;
         case (state)
            PREPARACAO: begin
               trg_cnt   <= '0;
               cyc_cnt   <= '0;
               tmo_cnt   <= '0;
               bcd       <= 12'h000;
               timed_out <= 1'b0;
            end
            ENVIA_TRIGGER: begin
               if (!trg_done) trg_cnt <= trg_cnt + TRG_W'(1);
            end
            ESPERA_ECHO, MEDINDO: begin
               tmo_cnt <= tmo_cnt + TMO_W'(1);
               if (echo_s) begin
                  if (cyc_cnt == CYC_W'(CYCLES_PER_CM - 1)) begin
                     cyc_cnt <= '0;
                     bcd     <= bcd_inc;
                  end else begin
                     cyc_cnt <= cyc_cnt + CYC_W'(1);
                  end
               end
               if (tmo_exit) timed_out <= 1'b1;
            end
            ARMAZENAMENTO: begin
               medida_q  <= timed_out ? 12'h999 : bcd;
               timeout_q <= timed_out;
            end
            default: ;
         endcase
      end
   end

   assign bus.trigger   = trigger_q;
   assign bus.pronto    = pronto_q;
   assign bus.db_estado = db_q;
   assign bus.medida    = medida_q;
   assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_interface_hcsr04.sv
// Randomised self-checking bench for interface_hcsr04; three instances cover the
// different parameter sets, and a reference model predicts distance from echo width.
module tb_interface_hcsr04;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic medir_d = 1'b0;
   logic echo_d = 1'b0;
   int   sel = 0;

   int   n_vec = 0;
   int   n_err = 0;
   int   prt_cnt = 0;

   logic        obs_trigger;
   logic        obs_pronto;
   logic        obs_tmo;
   logic [11:0] obs_medida;
   logic [3:0]  obs_db;

   localparam int TRIG = 5;

   always #5 clock = ~clock;

   interface_hcsr04_if ifa ();
   interface_hcsr04_if ifb ();
   interface_hcsr04_if ifc ();

   assign ifa.medir = medir_d && (sel == 0);
   assign ifa.echo  = echo_d  && (sel == 0);
   assign ifb.medir = medir_d && (sel == 1);
   assign ifb.echo  = echo_d  && (sel == 1);
   assign ifc.medir = medir_d && (sel == 2);
   assign ifc.echo  = echo_d  && (sel == 2);

   interface_hcsr04 #(.TRIGGER_CYCLES(TRIG), .CYCLES_PER_CM(4), .TIMEOUT_CYCLES(200))
      dut_a (.clock(clock), .reset(reset), .bus(ifa));
   interface_hcsr04 #(.TRIGGER_CYCLES(TRIG), .CYCLES_PER_CM(4), .TIMEOUT_CYCLES(2000))
      dut_b (.clock(clock), .reset(reset), .bus(ifb));
   interface_hcsr04 #(.TRIGGER_CYCLES(TRIG), .CYCLES_PER_CM(1), .TIMEOUT_CYCLES(5000))
      dut_c (.clock(clock), .reset(reset), .bus(ifc));

   always_comb begin
      obs_trigger = ifa.trigger;
      obs_pronto  = ifa.pronto;
      obs_tmo     = ifa.timeout;
      obs_medida  = ifa.medida;
      obs_db      = ifa.db_estado;
      if (sel == 1) begin
         obs_trigger = ifb.trigger;
         obs_pronto  = ifb.pronto;
         obs_tmo     = ifb.timeout;
         obs_medida  = ifb.medida;
         obs_db      = ifb.db_estado;
      end else if (sel == 2) begin
         obs_trigger = ifc.trigger;
         obs_pronto  = ifc.pronto;
         obs_tmo     = ifc.timeout;
         obs_medida  = ifc.medida;
         obs_db      = ifc.db_estado;
      end
   end

   always @(negedge clock) if (obs_pronto) prt_cnt <= prt_cnt + 1;

   function automatic int cpc_of(input int s);
      return (s == 2) ? 1 : 4;
   endfunction

   function automatic int tmo_of(input int s);
      return (s == 0) ? 200 : ((s == 1) ? 2000 : 5000);
   endfunction

   // Reference: centimetres = floor(width / cycles-per-cm), clamped to 999, in BCD
   function automatic logic [11:0] to_bcd(input int v);
      int c;
      c = (v > 999) ? 999 : v;
      return {4'(c / 100), 4'((c / 10) % 10), 4'(c % 10)};
   endfunction

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic wait_pronto(input int bound, output int lat);
      lat = 0;
      do begin
         @(posedge clock);
         @(negedge clock);
         lat++;
      end while (!obs_pronto && lat < bound);
   endtask

   // One measurement; w == 0 means no echo at all (timeout path)
   task automatic run_meas(input int s, input int dly, input int w, input bit busy);
      int          lat;
      int          tlen;
      int          base;
      bit          exp_to;
      logic [11:0] exp_m;
      sel    = s;
      exp_to = (w == 0);
      exp_m  = exp_to ? 12'h999 : to_bcd(w / cpc_of(s));
      base   = prt_cnt;

      @(posedge clock); #1 medir_d = 1'b1;
      @(posedge clock); #1 medir_d = 1'b0;
      @(negedge clock);
      chk("trig_early", 32'(obs_trigger), 0);
      @(posedge clock); @(negedge clock);
      chk("trig_rise", 32'(obs_trigger), 1);
      chk("db_trigger", 32'(obs_db), 2);
      tlen = 1;
      do begin
         @(posedge clock); @(negedge clock);
         if (obs_trigger) tlen++;
      end while (obs_trigger && tlen < 100);
      chk("trig_len", tlen, TRIG);
      chk("db_espera", 32'(obs_db), 3);

      if (w > 0) begin
         repeat (dly) @(posedge clock);
         #1 echo_d = 1'b1;
         for (int i = 0; i < w; i++) begin
            @(posedge clock); #1;
            medir_d = busy && (i == w / 2);
         end
         echo_d  = 1'b0;
         medir_d = 1'b0;
         wait_pronto(12, lat);
         chk("done_lat", lat, 4);
      end else begin
         wait_pronto(tmo_of(s) + 50, lat);
         chk("tmo_lat", 32'(lat >= tmo_of(s) && lat <= tmo_of(s) + 3), 1);
      end
      chk("pronto", 32'(obs_pronto), 1);
      chk("medida", 32'(obs_medida), 32'(exp_m));
      chk("timeout", 32'(obs_tmo), 32'(exp_to));
      @(posedge clock); @(negedge clock);
      chk("pronto_1cyc", 32'(obs_pronto), 0);
      chk("db_idle", 32'(obs_db), 0);
      chk("pronto_count", prt_cnt - base, 1);
   endtask

   task automatic reset_during_trigger();
      int base;
      sel  = 0;
      base = prt_cnt;
      @(posedge clock); #1 medir_d = 1'b1;
      @(posedge clock); #1 medir_d = 1'b0;
      @(posedge clock); #1;
      chk("rst_trig_before", 32'(obs_trigger), 1);
      reset = 1'b0;
      @(posedge clock); #1 reset = 1'b1;
      @(negedge clock);
      chk("rst_trigger", 32'(obs_trigger), 0);
      chk("rst_db", 32'(obs_db), 0);
      chk("rst_medida", 32'(obs_medida), 0);
      chk("rst_pronto", 32'(obs_pronto), 0);
      repeat (30) @(posedge clock);
      @(negedge clock);
      chk("rst_no_pronto", prt_cnt - base, 0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int s;
      int w;
      int dly;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("reset_trigger", 32'(obs_trigger), 0);
      chk("reset_pronto", 32'(obs_pronto), 0);
      chk("reset_medida", 32'(obs_medida), 0);
      chk("reset_timeout", 32'(obs_tmo), 0);
      chk("reset_db", 32'(obs_db), 0);
      @(posedge clock); #1 reset = 1'b1;

      run_meas(0, 10, 50, 1'b0);
      run_meas(0, 10, 40, 1'b0);
      run_meas(1, 10, 399, 1'b0);
      run_meas(0, 0, 0, 1'b0);
      run_meas(0, 10, 50, 1'b0);
      run_meas(2, 5, 1200, 1'b0);
      run_meas(0, 10, 50, 1'b1);
      reset_during_trigger();
      run_meas(0, 10, 3, 1'b0);

      for (int i = 0; i < 12; i++) begin
         s = int'($urandom_range(0, 2));
         if (s == 0) begin
            w   = int'($urandom_range(1, 150));
            dly = int'($urandom_range(1, 20));
         end else begin
            w   = int'($urandom_range(1, 1800));
            dly = int'($urandom_range(1, 50));
         end
         run_meas(s, dly, w, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
